// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the imem req/ack handshake,
// arbitrates redirects and holds one fetched instruction for decode.
module fetch_ctrl #(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR   = PC_WIDTH'('h80)
) (
    input  logic                fc_clk,
    input  logic                fc_rst,
    input  logic                fc_i_stall,
    input  logic                fc_i_exc,
    input  logic                fc_i_jmp,
    input  logic [PC_WIDTH-1:0] fc_i_jmp_target,
    input  logic                fc_i_br_taken,
    input  logic [PC_WIDTH-1:0] fc_i_br_target,
    output logic                fc_o_imem_req,
    output logic [PC_WIDTH-1:0] fc_o_imem_addr,
    input  logic                fc_i_imem_ack,
    input  logic [31:0]         fc_i_imem_data,
    output logic                fc_o_valid,
    output logic [31:0]         fc_o_instr,
    output logic [PC_WIDTH-1:0] fc_o_instr_pc,
    output logic                fc_o_flush
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic [PC_WIDTH-1:0] target_q, target_d;
    logic                valid_q, valid_d;
    logic [31:0]         instr_q, instr_d;
    logic [PC_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                flush_q, flush_d;

    logic                redirect;
    logic [PC_WIDTH-1:0] raw_target;
    logic [PC_WIDTH-1:0] redirect_target;
    logic                buf_free;
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;

    always_comb begin
        redirect   = fc_i_exc | fc_i_jmp | fc_i_br_taken;
        raw_target = fc_i_br_target;
        if (fc_i_exc) begin
            raw_target = EXC_VECTOR;
        end else if (fc_i_jmp) begin
            raw_target = fc_i_jmp_target;
        end
        redirect_target = raw_target & ~PC_WIDTH'(3);
        buf_free        = ~valid_q | ~fc_i_stall;

        imem_req   = 1'b0;
        imem_addr  = '0;
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        target_d   = target_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        flush_d    = redirect;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                end
            end
            FETCH: begin
                imem_req  = buf_free;
                imem_addr = fetch_pc_q;
                if (imem_req) begin
                    addr_d = fetch_pc_q;
                end
                if (valid_q & ~fc_i_stall) begin
                    valid_d = 1'b0;
                end
                // A redirect with the request still unanswered must wait out the stale ack.
                if (redirect) begin
                    if (imem_req & ~fc_i_imem_ack) begin
                        target_d = redirect_target;
                        state_d  = DRAIN;
                    end else begin
                        fetch_pc_d = redirect_target;
                    end
                end else if (imem_req & fc_i_imem_ack) begin
                    valid_d    = 1'b1;
                    instr_d    = fc_i_imem_data;
                    instr_pc_d = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = addr_q;
                if (fc_i_imem_ack) begin
                    fetch_pc_d = redirect ? redirect_target : target_q;
                    state_d    = FETCH;
                end else if (redirect) begin
                    target_d = redirect_target;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge fc_clk) begin
        if (fc_rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_VECTOR;
            addr_q     <= '0;
            target_q   <= '0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            target_q   <= target_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            flush_q    <= flush_d;
        end
    end

    assign fc_o_imem_req  = imem_req;
    assign fc_o_imem_addr = imem_addr;
    assign fc_o_valid     = valid_q;
    assign fc_o_instr     = instr_q;
    assign fc_o_instr_pc  = instr_pc_q;
    assign fc_o_flush     = flush_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed walk through the fetch scenarios followed by
// random traffic, both checked against a queue-based reference model.
module tb_fetch_ctrl;

    localparam logic [31:0] EXC_VEC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst, stall, exc, jmp, br, ack;
    logic [31:0] jt, bt, data;
    logic        req, valid, flush;
    logic [31:0] addr, instr, ipc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .PC_WIDTH    (32),
        .RESET_VECTOR(32'h0),
        .EXC_VECTOR  (EXC_VEC)
    ) dut (
        .fc_clk         (clk),
        .fc_rst         (rst),
        .fc_i_stall     (stall),
        .fc_i_exc       (exc),
        .fc_i_jmp       (jmp),
        .fc_i_jmp_target(jt),
        .fc_i_br_taken  (br),
        .fc_i_br_target (bt),
        .fc_o_imem_req  (req),
        .fc_o_imem_addr (addr),
        .fc_i_imem_ack  (ack),
        .fc_i_imem_data (data),
        .fc_o_valid     (valid),
        .fc_o_instr     (instr),
        .fc_o_instr_pc  (ipc),
        .fc_o_flush     (flush)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    // Reference model: a buffer queue, the next PC, and a "stale fetch" flag.
    entry_t      m_buf[$];
    bit          m_started, m_stale, m_flush;
    logic [31:0] m_next_pc, m_stale_addr, m_redirect_to;

    bit          obs_req, obs_valid, obs_flush;
    logic [31:0] obs_addr, obs_pc;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_buf.delete();
        m_started = 1'b0;
        m_stale   = 1'b0;
        m_flush   = 1'b0;
        m_next_pc = 32'h0;
    endtask

    task automatic resetDut();
        rst = 1'b1; stall = 1'b0; exc = 1'b0; jmp = 1'b0; br = 1'b0;
        ack = 1'b0; jt = '0; bt = '0; data = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_req", 32'(req), 32'h0);
        checkOutput("rst_addr", addr, 32'h0);
        checkOutput("rst_valid", 32'(valid), 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_instr_pc", ipc, 32'h0);
        checkOutput("rst_flush", 32'(flush), 32'h0);
        rst = 1'b0;
        modelReset();
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic applyStimulus(input bit s, input bit ex, input bit jp, input logic [31:0] jtgt,
                                 input bit bb, input logic [31:0] btgt, input bit ack_en);
        bit          redirect, m_req, consumed;
        logic [31:0] raw, tgt, m_addr;
        entry_t      ent;
        redirect = ex | jp | bb;
        raw      = ex ? EXC_VEC : (jp ? jtgt : btgt);
        tgt      = raw - (raw % 4);
        if (!m_started) begin
            m_req = 1'b0; m_addr = 32'h0;
        end else if (m_stale) begin
            m_req = 1'b1; m_addr = m_stale_addr;
        end else begin
            m_req = (m_buf.size() == 0) || !s; m_addr = m_next_pc;
        end
        stall = s; exc = ex; jmp = jp; jt = jtgt; br = bb; bt = btgt;
        ack   = m_req & ack_en;
        data  = $urandom();
        #1;
        obs_req = req; obs_addr = addr; obs_valid = valid; obs_pc = ipc; obs_flush = flush;
        checkOutput("req", 32'(req), 32'(m_req));
        if (m_req) checkOutput("addr", addr, m_addr);
        checkOutput("valid", 32'(valid), 32'(m_buf.size() != 0));
        if (m_buf.size() != 0) begin
            checkOutput("instr", instr, m_buf[0].instr);
            checkOutput("instr_pc", ipc, m_buf[0].pc);
        end
        checkOutput("flush", 32'(flush), 32'(m_flush));

        consumed = (m_buf.size() != 0) && !s;
        m_flush  = redirect;
        if (!m_started) begin
            m_started = 1'b1;
            if (redirect) m_next_pc = tgt;
        end else if (m_stale) begin
            if (ack) begin
                m_next_pc = redirect ? tgt : m_redirect_to;
                m_stale   = 1'b0;
            end else if (redirect) begin
                m_redirect_to = tgt;
            end
        end else begin
            if (consumed) void'(m_buf.pop_front());
            if (redirect) begin
                if (m_req && !ack) begin
                    m_stale       = 1'b1;
                    m_stale_addr  = m_next_pc;
                    m_redirect_to = tgt;
                end else begin
                    m_next_pc = tgt;
                end
            end else if (ack) begin
                ent.instr = data;
                ent.pc    = m_next_pc;
                m_buf.push_back(ent);
                m_next_pc = m_next_pc + 32'd4;
            end
        end
        if (redirect) m_buf.delete();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetDut();

        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("tp_idle_req", 32'(obs_req), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("tp_first_req", 32'(obs_req), 32'h1);
        checkOutput("tp_first_addr", obs_addr, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("tp_pc0", obs_pc, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("tp_pc4", obs_pc, 32'h4);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 1);
            checkOutput("tp_stall_pc", obs_pc, 32'h8);
            checkOutput("tp_stall_req", 32'(obs_req), 32'h0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("tp_resume_addr", obs_addr, 32'hC);

        applyStimulus(1, 0, 1, 32'h103, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("tp_jmp_flush", 32'(obs_flush), 32'h1);
        checkOutput("tp_jmp_valid", 32'(obs_valid), 32'h0);
        checkOutput("tp_jmp_addr", obs_addr, 32'h100);
        applyStimulus(1, 0, 1, 32'h20, 0, 0, 1);
        checkOutput("tp_flush_once", 32'(obs_flush), 32'h0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h40, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            checkOutput("tp_drain_addr", obs_addr, 32'h20);
            checkOutput("tp_drain_req", 32'(obs_req), 32'h1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("tp_drain_discard", 32'(obs_valid), 32'h0);
        checkOutput("tp_br_addr", obs_addr, 32'h40);

        applyStimulus(0, 1, 1, 32'h200, 1, 32'h300, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("tp_prio_addr", obs_addr, 32'h80);

        applyStimulus(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("tp_wrap_top", obs_addr, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("tp_wrap_addr", obs_addr, 32'h0);
        checkOutput("tp_wrap_pc", obs_pc, 32'hFFFF_FFFC);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                resetDut();
            end else begin
                applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                              $urandom_range(0, 7) == 0, $urandom(),
                              $urandom_range(0, 5) == 0, $urandom(),
                              $urandom_range(0, 1) == 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
